// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and life-count helpers for the game sequencer
package game_pkg;

  typedef enum logic [2:0] {
    ST_TITLE    = 3'd0,
    ST_PLAY     = 3'd1,
    ST_RESPAWN  = 3'd2,
    ST_INVULN   = 3'd3,
    ST_GAMEOVER = 3'd4,
    ST_WIN      = 3'd5
  } state_t;

  localparam int START_LIVES_DEF = 5;
  localparam int MAX_LIVES_DEF   = 7;

  // Extra-life increment that saturates at the configured ceiling.
  function automatic logic [2:0] lives_inc(input logic [2:0] cur, input logic [2:0] ceil_v);
    return (cur < ceil_v) ? cur + 3'd1 : ceil_v;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge detector on a synchronous level input
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic sig_d;
  logic sig_q;

  // Delayed copy is simply the current level.
  always_comb begin
    sig_d = sig_in;
  end

  // One-cycle registered copy used to spot the 0->1 transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_d;
  end

  assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game sequencer owning lives, hit recovery and invulnerability blink
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int START_LIVES    = START_LIVES_DEF,
  parameter int MAX_LIVES      = MAX_LIVES_DEF,
  parameter int INVIS_CYCLES   = 150000000,
  parameter int BLINK_HALF     = 6250000,
  parameter int RESPAWN_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       bm_hb_on,
  input  logic       enemy_on,
  input  logic       exp_on,
  input  logic       life_up,
  input  logic       level_clear,
  output logic [2:0] state,
  output logic [2:0] lives,
  output logic       game_active,
  output logic       invuln,
  output logic       bm_visible,
  output logic       hit_pulse,
  output logic       gameover
);

  localparam logic [2:0]  START_L    = 3'(START_LIVES);
  localparam logic [2:0]  MAX_L      = 3'(MAX_LIVES);
  localparam logic [27:0] INV_LAST   = 28'(INVIS_CYCLES - 1);
  localparam logic [25:0] RESP_LAST  = 26'(RESPAWN_CYCLES - 1);
  localparam logic [22:0] BLINK_LAST = 23'(BLINK_HALF - 1);

  state_t      state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [27:0] inv_cnt_q, inv_cnt_d;
  logic [25:0] resp_cnt_q, resp_cnt_d;
  logic [22:0] blink_cnt_q, blink_cnt_d;
  logic        vis_q, vis_d;
  logic        hit_pulse_q, hit_pulse_d;

  logic        start_rise;
  logic        hit;
  logic [2:0]  lives_plus;
  logic [22:0] blink_step;
  logic        vis_step;

  edge_detect u_start_edge (
    .clk    (clk),
    .rst_n  (reset),
    .sig_in (start_btn),
    .rise   (start_rise)
  );

  assign hit        = bm_hb_on & (enemy_on | exp_on);
  assign lives_plus = lives_inc(lives_q, MAX_L);

  // Free-running blink phase used while recovering from a hit.
  always_comb begin
    blink_step = blink_cnt_q + 23'd1;
    vis_step   = vis_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_step = 23'd0;
      vis_step   = ~vis_q;
    end
  end

  // Next-state, life bookkeeping and counter sequencing.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    inv_cnt_d   = inv_cnt_q;
    resp_cnt_d  = resp_cnt_q;
    blink_cnt_d = blink_cnt_q;
    vis_d       = vis_q;
    hit_pulse_d = 1'b0;

    case (state_q)
      ST_TITLE: begin
        if (start_rise) begin
          state_d     = ST_PLAY;
          lives_d     = START_L;
          inv_cnt_d   = '0;
          resp_cnt_d  = '0;
          blink_cnt_d = '0;
          vis_d       = 1'b1;
        end
      end

      ST_PLAY: begin
        if (hit) begin
          hit_pulse_d = 1'b1;
          // A simultaneous extra life cancels the loss, even on the last life.
          if (lives_q > 3'd1 || life_up) begin
            state_d     = ST_RESPAWN;
            lives_d     = life_up ? lives_q : lives_q - 3'd1;
            resp_cnt_d  = '0;
            blink_cnt_d = '0;
            vis_d       = 1'b1;
          end else begin
            state_d = ST_GAMEOVER;
            lives_d = 3'd0;
          end
        end else if (level_clear) begin
          state_d = ST_WIN;
        end else if (life_up) begin
          lives_d = lives_plus;
        end
      end

      ST_RESPAWN: begin
        if (life_up) lives_d = lives_plus;
        blink_cnt_d = blink_step;
        vis_d       = vis_step;
        if (resp_cnt_q == RESP_LAST) begin
          state_d   = ST_INVULN;
          inv_cnt_d = '0;
        end else begin
          resp_cnt_d = resp_cnt_q + 26'd1;
        end
      end

      ST_INVULN: begin
        if (life_up) lives_d = lives_plus;
        blink_cnt_d = blink_step;
        vis_d       = vis_step;
        if (level_clear) begin
          state_d = ST_WIN;
        end else if (inv_cnt_q == INV_LAST) begin
          state_d = ST_PLAY;
        end else begin
          inv_cnt_d = inv_cnt_q + 28'd1;
        end
      end

      ST_GAMEOVER, ST_WIN: begin
        if (start_rise) state_d = ST_TITLE;
      end

      default: state_d = ST_TITLE;
    endcase
  end

  // State and counter registers; reset aborts straight back to the title screen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_TITLE;
      lives_q     <= START_L;
      inv_cnt_q   <= '0;
      resp_cnt_q  <= '0;
      blink_cnt_q <= '0;
      vis_q       <= 1'b1;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      inv_cnt_q   <= inv_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      vis_q       <= vis_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  // Outputs decoded directly from the current state so gating has no extra lag.
  always_comb begin
    state       = state_q;
    lives       = lives_q;
    hit_pulse   = hit_pulse_q;
    game_active = (state_q == ST_PLAY) || (state_q == ST_INVULN);
    invuln      = (state_q == ST_RESPAWN) || (state_q == ST_INVULN);
    gameover    = (state_q == ST_GAMEOVER);
    bm_visible  = invuln ? vis_q : 1'b1;
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed self-checking bench for game_flow_ctrl
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_btn = 1'b0;
  logic       bm_hb_on = 1'b0;
  logic       enemy_on = 1'b0;
  logic       exp_on = 1'b0;
  logic       life_up = 1'b0;
  logic       level_clear = 1'b0;
  logic [2:0] state;
  logic [2:0] lives;
  logic       game_active;
  logic       invuln;
  logic       bm_visible;
  logic       hit_pulse;
  logic       gameover;

  int total = 0;
  int bad   = 0;

  game_flow_ctrl #(
    .START_LIVES    (5),
    .MAX_LIVES      (7),
    .INVIS_CYCLES   (20),
    .BLINK_HALF     (3),
    .RESPAWN_CYCLES (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_btn   (start_btn),
    .bm_hb_on    (bm_hb_on),
    .enemy_on    (enemy_on),
    .exp_on      (exp_on),
    .life_up     (life_up),
    .level_clear (level_clear),
    .state       (state),
    .lives       (lives),
    .game_active (game_active),
    .invuln      (invuln),
    .bm_visible  (bm_visible),
    .hit_pulse   (hit_pulse),
    .gameover    (gameover)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] want, input string tag);
    int n = 0;
    while (state !== want && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(state), 32'(want));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_lives"}, 32'(lives), 5);
    chk({tag, "_active"}, 32'(game_active), 0);
    chk({tag, "_invuln"}, 32'(invuln), 0);
    chk({tag, "_visible"}, 32'(bm_visible), 1);
    chk({tag, "_hitpulse"}, 32'(hit_pulse), 0);
    chk({tag, "_gameover"}, 32'(gameover), 0);
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  task automatic single_hit(input logic with_life);
    bm_hb_on = 1'b1;
    enemy_on = 1'b1;
    life_up  = with_life;
    step();
    bm_hb_on = 1'b0;
    enemy_on = 1'b0;
    life_up  = 1'b0;
  endtask

  initial begin
    // Reset values while held in reset.
    step();
    step();
    chk_reset_vals("rst_hold");
    reset = 1'b1;
    step();
    chk_reset_vals("rst_rel");

    // Start into PLAY.
    pulse_start();
    chk("start_state", 32'(state), 1);
    chk("start_active", 32'(game_active), 1);
    chk("start_lives", 32'(lives), 5);

    // First hit: RESPAWN 10 cycles, INVULN 20 cycles, blink period 6.
    single_hit(1'b0);
    chk("hit1_pulse", 32'(hit_pulse), 1);
    chk("hit1_lives", 32'(lives), 4);
    chk("hit1_active", 32'(game_active), 0);
    for (int k = 0; k < 30; k++) begin
      if (k == 10) begin
        bm_hb_on = 1'b1;
        exp_on   = 1'b1;
      end
      chk($sformatf("rec_state_%0d", k), 32'(state), (k < 10) ? 2 : 3);
      chk($sformatf("rec_vis_%0d", k), 32'(bm_visible), ((k / 3) % 2 == 0) ? 1 : 0);
      chk($sformatf("rec_lives_%0d", k), 32'(lives), 4);
      chk($sformatf("rec_inv_%0d", k), 32'(invuln), 1);
      if (k > 0) chk($sformatf("rec_hp_%0d", k), 32'(hit_pulse), 0);
      step();
    end
    chk("back_play_state", 32'(state), 1);
    chk("back_play_lives", 32'(lives), 4);
    chk("back_play_vis", 32'(bm_visible), 1);
    step();
    chk("held_hit_state", 32'(state), 2);
    chk("held_hit_lives", 32'(lives), 3);
    chk("held_hit_pulse", 32'(hit_pulse), 1);
    bm_hb_on = 1'b0;
    exp_on   = 1'b0;
    wait_state(3'd1, "rec2_play");

    // Drain lives down to 1.
    single_hit(1'b0);
    chk("hit3_lives", 32'(lives), 2);
    wait_state(3'd1, "rec3_play");
    single_hit(1'b0);
    chk("hit4_lives", 32'(lives), 1);
    wait_state(3'd1, "rec4_play");

    // Last life saved by a simultaneous extra life.
    single_hit(1'b1);
    chk("save_state", 32'(state), 2);
    chk("save_lives", 32'(lives), 1);
    chk("save_pulse", 32'(hit_pulse), 1);
    wait_state(3'd1, "rec5_play");

    // Final hit: game over.
    single_hit(1'b0);
    chk("go_state", 32'(state), 4);
    chk("go_lives", 32'(lives), 0);
    chk("go_flag", 32'(gameover), 1);
    chk("go_active", 32'(game_active), 0);
    chk("go_pulse", 32'(hit_pulse), 1);
    step();
    chk("go_pulse_once", 32'(hit_pulse), 0);

    // Back to title, then a new game reloads lives.
    pulse_start();
    chk("title_state", 32'(state), 0);
    chk("title_gameover", 32'(gameover), 0);
    step();
    pulse_start();
    chk("restart_state", 32'(state), 1);
    chk("restart_lives", 32'(lives), 5);

    // Extra lives saturate at seven.
    for (int i = 0; i < 3; i++) begin
      life_up = 1'b1;
      step();
      life_up = 1'b0;
      chk($sformatf("lifeup_%0d", i), 32'(lives), (i == 0) ? 6 : 7);
      step();
    end

    // Hit beats level_clear in the same cycle.
    level_clear = 1'b1;
    single_hit(1'b0);
    level_clear = 1'b0;
    chk("prio_state", 32'(state), 2);
    chk("prio_lives", 32'(lives), 6);
    chk("prio_pulse", 32'(hit_pulse), 1);

    // Asynchronous reset in the middle of INVULN.
    wait_state(3'd3, "reach_invuln");
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    step();
    reset = 1'b1;
    step();

    // Level clear goes to WIN; lives held and extra lives ignored there.
    pulse_start();
    chk("win_pre_state", 32'(state), 1);
    level_clear = 1'b1;
    step();
    level_clear = 1'b0;
    chk("win_state", 32'(state), 5);
    chk("win_active", 32'(game_active), 0);
    chk("win_lives", 32'(lives), 5);
    life_up = 1'b1;
    step();
    life_up = 1'b0;
    chk("win_lifeup_ignored", 32'(lives), 5);
    pulse_start();
    chk("win_to_title", 32'(state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer. Owns Bomberman's life count and the hit/invulnerability window, and sequences the game through title, play, hit recovery, respawn, game over and win.
- Downstream blocks use its outputs to gate movement, bomb placement, enemy motion and sprite blinking.
- The arena background shade is derived from its `lives` output.

Parameters:
- START_LIVES, 5: lives loaded on game start.
- MAX_LIVES, 7: saturation ceiling for extra-life pickups (must be ≤ 7).
- INVIS_CYCLES, 150000000: length of the post-hit invulnerability window, in clk cycles.
- BLINK_HALF, 6250000: half-period of the sprite blink during invulnerability, in clk cycles.
- RESPAWN_CYCLES, 50000000: freeze time after a hit before control returns.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous reset, active-low.
- start_btn, input, 1: start/restart button; synchronous level, rising-edge detected internally.
- bm_hb_on, input, 1: current pixel lies inside Bomberman's hitbox.
- enemy_on, input, 1: current pixel lies on an enemy.
- exp_on, input, 1: current pixel lies on an explosion.
- life_up, input, 1: one-cycle pulse when an extra-life item is collected.
- level_clear, input, 1: one-cycle pulse when all enemies are dead.
- state, output, 3: current FSM state encoding.
- lives, output, 3: current life count.
- game_active, output, 1: movement and bombs enabled.
- invuln, output, 1: hits are ignored.
- bm_visible, output, 1: Bomberman sprite enable (blinks during invulnerability).
- hit_pulse, output, 1: one-cycle strobe when a hit is accepted (drives the audio/score blocks).
- gameover, output, 1: asserted in the GAMEOVER state.

Behaviour:
- Reset (reset low, asynchronous):
  - state = TITLE, lives = START_LIVES.
  - All counters = 0.
  - game_active = 0, invuln = 0, bm_visible = 1, hit_pulse = 0, gameover = 0.
- hit = bm_hb_on & (enemy_on | exp_on), evaluated every cycle; it is a pixel-rate raw signal.
- start_rise = start_btn & ~start_d, where start_d is a one-cycle registered copy of start_btn (reset 0).
- TITLE:
  - start_rise → PLAY.
  - On the same edge: lives ← START_LIVES, all counters cleared.
- PLAY:
  - game_active = 1.
  - A hit while lives > 1 → RESPAWN; lives ← lives − 1; hit_pulse = 1 for the cycle after the edge; resp_cnt ← 0.
  - A hit while lives == 1 → GAMEOVER; lives ← 0; hit_pulse = 1.
  - level_clear → WIN.
  - Priority: hit over level_clear when both occur in the same cycle.
- RESPAWN:
  - game_active = 0, invuln = 1.
  - resp_cnt increments each cycle; at RESPAWN_CYCLES−1 → INVULN, inv_cnt ← 0.
- INVULN:
  - game_active = 1, invuln = 1; all hits ignored.
  - inv_cnt increments each cycle; at INVIS_CYCLES−1 → PLAY.
  - level_clear → WIN.
- Blink:
  - bm_visible toggles every BLINK_HALF cycles in RESPAWN and INVULN; blink_cnt restarts on entry to RESPAWN.
  - bm_visible = 1 in all other states.
- GAMEOVER:
  - gameover = 1, game_active = 0.
  - start_rise → TITLE (lives is reloaded on the next start).
- WIN:
  - game_active = 0; lives held.
  - start_rise → TITLE.
- life_up:
  - Accepted in PLAY, RESPAWN and INVULN: lives ← min(lives + 1, MAX_LIVES).
  - Ignored in TITLE, GAMEOVER and WIN.
  - If life_up and an accepted hit occur in the same cycle, the net lives change is 0 (the hit is still accepted, with hit_pulse and transition to RESPAWN).
  - Exception: a hit at lives == 1 together with life_up → RESPAWN with lives = 1, not GAMEOVER.
- Counter widths:
  - inv_cnt 28 b, resp_cnt 26 b, blink_cnt 23 b.
  - Compare with ==, never wrap.
- The reset deassertion edge must be synchronised by the top level; this block assumes it is.
- A reset asserted mid-game aborts immediately to the reset values above.
- Output timing:
  - All outputs are registered or decoded from state.
  - gameover and game_active follow state with 0 added latency.

Decomposition:
- Package game_pkg:
  - State localparams: TITLE=0, PLAY=1, RESPAWN=2, INVULN=3, GAMEOVER=4, WIN=5.
  - Default START_LIVES and MAX_LIVES.
- Sub-module edge_detect (rising edge, registered, asynchronous active-low reset), instantiated for start_btn.
- The lives/background colour LUT stays in the existing display path, fed by the lives output.

Test Plan (INVIS_CYCLES=20, RESPAWN_CYCLES=10, BLINK_HALF=3):
- Reset low, then release → state=0, lives=5, game_active=0, bm_visible=1; start_btn pulse → state=1, game_active=1.
- In PLAY, assert bm_hb_on & enemy_on for 1 cycle:
  - one hit_pulse; lives=4; state=2 for 10 cycles, then 3 for 20 cycles, then 1.
  - bm_visible toggles every 3 cycles during those 30 cycles.
- In INVULN, hold bm_hb_on & exp_on high continuously → lives stays 4, no hit_pulse; return to PLAY, where the held hit causes lives=3.
- Five accepted hits from the start:
  - the final hit goes to GAMEOVER with lives=0 and gameover=1.
  - start_btn → TITLE; a second start_btn → lives=5.
- Three life_up pulses from lives=5 → lives 6, 7, 7 (saturates).
- Simultaneous hit and life_up at lives=1 → state=2, lives=1, hit_pulse=1.
- level_clear together with a hit in PLAY → RESPAWN (not WIN).
- Reset low during INVULN → all outputs return to reset values in the same cycle.
